// File: rtl/conv_pkg.sv
// Shared types for the convolution frame streamer: FSM states, token layout, FIFO depth.
package conv_pkg;

  localparam int STREAM_FIFO_DEPTH = 2;
  localparam int CONV_DATA_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } conv_stream_state_t;

  // Marker order is fixed: sol is the MSB of the flag field.
  typedef struct packed {
    logic sol;
    logic eol;
    logic sof;
    logic eof;
  } conv_flags_t;

  typedef struct packed {
    logic [CONV_DATA_WIDTH-1:0] data;
    conv_flags_t                flags;
  } conv_token_t;

endpackage

// File: rtl/conv_stream_fifo.sv
// Two-entry show-ahead token FIFO; the head entry is presented directly on head_tok.
module conv_stream_fifo
  import conv_pkg::*;
#(
  parameter int W = 12
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   push,
  input  logic [W-1:0]                           push_tok,
  input  logic                                   pop,
  output logic [W-1:0]                           head_tok,
  output logic                                   head_vld,
  output logic [$clog2(STREAM_FIFO_DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(STREAM_FIFO_DEPTH);
  localparam int CW = $clog2(STREAM_FIFO_DEPTH + 1);

  logic [STREAM_FIFO_DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]                       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                       count_q, count_d;
  logic                                do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q < CW'(STREAM_FIFO_DEPTH)) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_tok;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_tok = mem_q[rd_ptr_q];
  assign head_vld = (count_q != '0);
  assign count    = count_q;

endmodule

// File: rtl/conv_frame_streamer.sv
// Reads a stored frame in raster order and streams it with valid/ready and line/frame markers.
// Define CONV_STREAM_PAD_INSERT_EN to wrap the frame in a one-pixel zero border.
module conv_frame_streamer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH    = CONV_DATA_WIDTH,
  parameter int BUFFER_LENGTH = 2000,
  parameter int ADDR_WIDTH    = 22
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [$clog2(BUFFER_LENGTH)-1:0] frame_column_size,
  input  logic [$clog2(BUFFER_LENGTH)-1:0] frame_row_size,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  output logic                             mem_rd_en,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic [DATA_WIDTH-1:0]            mem_rd_data,
  output logic [DATA_WIDTH-1:0]            out_point,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_sol,
  output logic                             out_eol,
  output logic                             out_sof,
  output logic                             out_eof,
  output logic                             busy,
  output logic                             done
);

  // One extra bit so the padded size (C+2) never wraps.
  localparam int EW = $clog2(BUFFER_LENGTH) + 1;
  localparam int TW = DATA_WIDTH + $bits(conv_flags_t);
  localparam int CW = $clog2(STREAM_FIFO_DEPTH + 1);

`ifdef CONV_STREAM_PAD_INSERT_EN
  localparam logic [EW-1:0] PAD_EXTRA = EW'(2);
`else
  localparam logic [EW-1:0] PAD_EXTRA = '0;
`endif

  conv_stream_state_t    state_q, state_d;
  logic [EW-1:0]         col_q, col_d, row_q, row_d;
  logic [EW-1:0]         ce_q, ce_d, re_q, re_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  zero_done_q, zero_done_d;
  logic                  vld_pipe_q, vld_pipe_d;
  logic                  pad_pipe_q, pad_pipe_d;
  conv_flags_t           flags_pipe_q, flags_pipe_d;

  logic                  start_acc, size_zero;
  logic                  last_col, last_row, is_border;
  logic                  issue, pop, credit_ok, drain_empty;
  logic [TW-1:0]         push_tok, head_tok;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  fifo_vld;
  logic [CW-1:0]         fifo_count;

  assign start_acc = start && (state_q == IDLE);
  assign size_zero = (frame_column_size == '0) || (frame_row_size == '0);
  assign last_col  = (col_q == ce_q - 1'b1);
  assign last_row  = (row_q == re_q - 1'b1);

`ifdef CONV_STREAM_PAD_INSERT_EN
  assign is_border = (row_q == '0) || last_row || (col_q == '0) || last_col;
`else
  assign is_border = 1'b0;
`endif

  // Tokens already queued or in flight must fit in the FIFO after this cycle's pop.
  assign pop         = fifo_vld & out_ready;
  assign credit_ok   = ({1'b0, fifo_count} + {2'b00, vld_pipe_q}) < (3'd2 + {2'b00, pop});
  assign drain_empty = (fifo_count == '0) && !vld_pipe_q;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc && !size_zero) state_d = RUN;
      RUN:     if (issue && last_row && last_col) state_d = DRAIN;
      DRAIN:   if (drain_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    issue = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      RUN: begin
        issue = credit_ok;
        busy  = 1'b1;
      end
      DRAIN: begin
        busy = 1'b1;
        done = drain_empty;
      end
      default: ;
    endcase
    mem_rd_en = issue & ~is_border;
    done      = done | zero_done_q;
  end

  // Raster counters and the read pointer; border slots never advance the pointer.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    ce_d        = ce_q;
    re_d        = re_q;
    ptr_d       = ptr_q;
    zero_done_d = 1'b0;
    if (start_acc) begin
      ce_d        = EW'(frame_column_size) + PAD_EXTRA;
      re_d        = EW'(frame_row_size) + PAD_EXTRA;
      ptr_d       = base_addr;
      col_d       = '0;
      row_d       = '0;
      zero_done_d = size_zero;
    end else if (issue) begin
      if (mem_rd_en) ptr_d = ptr_q + 1'b1;
      if (last_col) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    vld_pipe_d       = issue;
    pad_pipe_d       = is_border;
    flags_pipe_d.sol = (col_q == '0);
    flags_pipe_d.eol = last_col;
    flags_pipe_d.sof = (row_q == '0) && (col_q == '0);
    flags_pipe_d.eof = last_row && last_col;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      ce_q         <= '0;
      re_q         <= '0;
      ptr_q        <= '0;
      zero_done_q  <= 1'b0;
      vld_pipe_q   <= 1'b0;
      pad_pipe_q   <= 1'b0;
      flags_pipe_q <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      ce_q         <= ce_d;
      re_q         <= re_d;
      ptr_q        <= ptr_d;
      zero_done_q  <= zero_done_d;
      vld_pipe_q   <= vld_pipe_d;
      pad_pipe_q   <= pad_pipe_d;
      flags_pipe_q <= flags_pipe_d;
    end
  end

  assign mem_addr  = ptr_q;
  assign push_data = pad_pipe_q ? {DATA_WIDTH{1'b0}} : mem_rd_data;
  assign push_tok  = {push_data, flags_pipe_q};

  conv_stream_fifo #(.W(TW)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (vld_pipe_q),
    .push_tok (push_tok),
    .pop      (pop),
    .head_tok (head_tok),
    .head_vld (fifo_vld),
    .count    (fifo_count)
  );

  assign out_valid = fifo_vld;
  assign {out_point, out_sol, out_eol, out_sof, out_eof} = head_tok;

endmodule

// File: tb/tb_conv_frame_streamer.sv
// Randomized bench for conv_frame_streamer with a raster-order reference scoreboard.
`timescale 1ns/1ps
module tb_conv_frame_streamer;

  localparam int DW = 8;
  localparam int BL = 2000;
  localparam int AW = 22;
  localparam int SW = $clog2(BL);
`ifdef CONV_STREAM_PAD_INSERT_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [SW-1:0] frame_column_size = '0;
  logic [SW-1:0] frame_row_size = '0;
  logic [AW-1:0] base_addr = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic [DW-1:0] out_point;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_sol, out_eol, out_sof, out_eof;
  logic          busy, done;

  conv_frame_streamer #(.DATA_WIDTH(DW), .BUFFER_LENGTH(BL), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .frame_column_size(frame_column_size), .frame_row_size(frame_row_size),
    .base_addr(base_addr), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .out_point(out_point), .out_valid(out_valid),
    .out_ready(out_ready), .out_sol(out_sol), .out_eol(out_eol), .out_sof(out_sof),
    .out_eof(out_eof), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame memory: contents are a keyed function of the address.
  logic [7:0] mem_key = 8'h00;
  function automatic logic [7:0] memv(input logic [AW-1:0] a);
    return a[7:0] ^ mem_key;
  endfunction
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= memv(mem_addr);

  int n_cmp = 0, n_bad = 0;
  int t0 = 0;
  bit mon_en = 1'b0;
  int rd_cnt, first_rd, first_vld, done_rel, done_cnt, xfer_cnt, last_xfer;
  int busy_first, stall_viol;
  logic busy_after;
  logic prev_hold;
  logic [DW+3:0] prev_out;
  logic [DW+3:0] exp_q[$];
  int exp_n, exp_reads;

  task automatic mon_clear();
    rd_cnt = 0; first_rd = -1; first_vld = -1; done_rel = -1; done_cnt = 0;
    xfer_cnt = 0; last_xfer = -1; busy_first = -1; busy_after = 1'bx;
    stall_viol = 0; prev_hold = 1'b0; prev_out = '0;
  endtask

  // Reference: walk the emitted frame, border slots zero, interior reads consecutive addresses.
  task automatic build_expected(input int c, input int r, input int base);
    int ce, re, k;
    logic [DW-1:0] d;
    logic [3:0] f;
    bit border;
    exp_q.delete();
    k = 0;
    ce = c + (PAD ? 2 : 0);
    re = r + (PAD ? 2 : 0);
    if (c != 0 && r != 0) begin
      for (int y = 0; y < re; y++)
        for (int x = 0; x < ce; x++) begin
          border = PAD && (y == 0 || y == re - 1 || x == 0 || x == ce - 1);
          d = border ? 8'h00 : memv(AW'(base + k));
          if (!border) k++;
          f = {x == 0, x == ce - 1, y == 0 && x == 0, y == re - 1 && x == ce - 1};
          exp_q.push_back({d, f});
        end
    end
    exp_n = exp_q.size();
    exp_reads = k;
  endtask

  // Monitor and scoreboard, sampled on the falling edge.
  initial begin
    int m_rel;
    logic [DW+3:0] m_out, e;
    mon_clear();
    forever begin
      @(negedge clk);
      if (mon_en) begin
        m_rel = cyc - t0;
        m_out = {out_point, out_sol, out_eol, out_sof, out_eof};
        if (mem_rd_en) begin rd_cnt++; if (first_rd < 0) first_rd = m_rel; end
        if (out_valid && first_vld < 0) first_vld = m_rel;
        if (busy && busy_first < 0) busy_first = m_rel;
        if (done_rel >= 0 && m_rel == done_rel + 1) busy_after = busy;
        if (done) begin done_cnt++; if (done_rel < 0) done_rel = m_rel; end
        if (prev_hold && (!out_valid || m_out !== prev_out)) stall_viol++;
        prev_hold = out_valid && !out_ready;
        prev_out = m_out;
        if (out_valid && out_ready) begin
          xfer_cnt++;
          last_xfer = m_rel;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL stream_extra: got token %h, required no further token", m_out);
          end else begin
            e = exp_q.pop_front();
            if (m_out !== e) begin
              n_bad++;
              $display("FAIL stream_token[%0d]: got %h, required %h", xfer_cnt - 1, m_out, e);
            end
          end
        end
      end
    end
  end

  // mode 0: ready high, 1: ready low in cycles 5..9, 2: random ready.
  task automatic run_frame(input int c, input int r, input int base, input int mode,
                           input int restart_at, output bit to);
    int rel;
    mon_clear();
    build_expected(c, r, base);
    @(posedge clk); #1;
    t0 = cyc;
    frame_column_size = SW'(c);
    frame_row_size = SW'(r);
    base_addr = AW'(base);
    mon_en = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rel = cyc - t0;
      start = (rel == 0) || (rel == restart_at);
      if (rel == restart_at) begin
        frame_column_size = SW'(3);
        frame_row_size = SW'(2);
        base_addr = AW'(0);
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(rel >= 5 && rel <= 9);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (done_cnt > 0 && rel >= done_rel + 3) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [AW+DW+7:0] v;
    repeat (3) @(posedge clk);
    #1;
    v = {mem_rd_en, mem_addr, out_valid, out_point, out_sol, out_eol, out_sof, out_eof, busy, done};
    n_cmp++;
    if (v !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h, required 0", v); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, out_valid, mem_rd_en} !== 4'b0) begin
      n_bad++; $display("FAIL idle_after_reset: got %b, required 0000", {busy, done, out_valid, mem_rd_en});
    end
  endtask

  task automatic test_basic();
    bit to;
    mem_key = 8'h00;
    run_frame(4, 3, 'h100, 0, -1, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL basic_timeout: got timeout, required done"); end
    n_cmp++; if (xfer_cnt !== exp_n) begin n_bad++; $display("FAIL basic_count: got %0d, required %0d", xfer_cnt, exp_n); end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL basic_missing: got %0d left, required 0", exp_q.size()); end
    n_cmp++; if (first_rd !== 1) begin n_bad++; $display("FAIL basic_first_rd: got %0d, required 1", first_rd); end
    n_cmp++; if (first_vld !== 3) begin n_bad++; $display("FAIL basic_first_valid: got %0d, required 3", first_vld); end
    n_cmp++; if (last_xfer !== 2 + exp_n) begin n_bad++; $display("FAIL basic_last_xfer: got %0d, required %0d", last_xfer, 2 + exp_n); end
    n_cmp++; if (done_rel !== 3 + exp_n) begin n_bad++; $display("FAIL basic_done_cycle: got %0d, required %0d", done_rel, 3 + exp_n); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL basic_done_pulses: got %0d, required 1", done_cnt); end
    n_cmp++; if (rd_cnt !== exp_reads) begin n_bad++; $display("FAIL basic_reads: got %0d, required %0d", rd_cnt, exp_reads); end
    n_cmp++; if (busy_first !== 1) begin n_bad++; $display("FAIL basic_busy_rise: got %0d, required 1", busy_first); end
    n_cmp++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL basic_busy_fall: got %b, required 0", busy_after); end
  endtask

  task automatic test_stall();
    bit to;
    mem_key = 8'h00;
    run_frame(4, 3, 'h100, 1, -1, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL stall_timeout: got timeout, required done"); end
    n_cmp++; if (xfer_cnt !== exp_n) begin n_bad++; $display("FAIL stall_count: got %0d, required %0d", xfer_cnt, exp_n); end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL stall_missing: got %0d left, required 0", exp_q.size()); end
    n_cmp++; if (stall_viol !== 0) begin n_bad++; $display("FAIL stall_stable: got %0d changes, required 0", stall_viol); end
    n_cmp++; if (last_xfer !== exp_n + 7) begin n_bad++; $display("FAIL stall_no_bubble: got %0d, required %0d", last_xfer, exp_n + 7); end
    n_cmp++; if (done_rel !== 8 + exp_n) begin n_bad++; $display("FAIL stall_done_cycle: got %0d, required %0d", done_rel, 8 + exp_n); end
  endtask

  task automatic test_random(input int c, input int r);
    bit to;
    mem_key = 8'($urandom);
    run_frame(c, r, int'($urandom_range(0, 'h3F_0000)), 2, -1, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL random_timeout %0dx%0d: got timeout, required done", c, r); end
    n_cmp++; if (xfer_cnt !== exp_n) begin n_bad++; $display("FAIL random_count: got %0d, required %0d", xfer_cnt, exp_n); end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL random_missing: got %0d left, required 0", exp_q.size()); end
    n_cmp++; if (rd_cnt !== exp_reads) begin n_bad++; $display("FAIL random_reads: got %0d, required %0d", rd_cnt, exp_reads); end
    n_cmp++; if (stall_viol !== 0) begin n_bad++; $display("FAIL random_stable: got %0d changes, required 0", stall_viol); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL random_done_pulses: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_small_frame();
    bit to;
    mem_key = 8'h5A;
    run_frame(2, 2, 'h40, 0, -1, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL small_timeout: got timeout, required done"); end
    n_cmp++; if (xfer_cnt !== exp_n) begin n_bad++; $display("FAIL small_count: got %0d, required %0d", xfer_cnt, exp_n); end
    n_cmp++; if (rd_cnt !== exp_reads) begin n_bad++; $display("FAIL small_reads: got %0d, required %0d", rd_cnt, exp_reads); end
    n_cmp++; if (done_rel !== 3 + exp_n) begin n_bad++; $display("FAIL small_done_cycle: got %0d, required %0d", done_rel, 3 + exp_n); end
  endtask

  task automatic test_zero(input int c, input int r);
    bit to;
    run_frame(c, r, 'h10, 0, -1, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL zero_timeout: got timeout, required done"); end
    n_cmp++; if (done_rel !== 1) begin n_bad++; $display("FAIL zero_done_cycle: got %0d, required 1", done_rel); end
    n_cmp++; if (rd_cnt !== 0) begin n_bad++; $display("FAIL zero_reads: got %0d, required 0", rd_cnt); end
    n_cmp++; if (first_vld !== -1) begin n_bad++; $display("FAIL zero_valid: got %0d, required -1", first_vld); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL zero_done_pulses: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_start_busy();
    bit to;
    mem_key = 8'hC3;
    run_frame(4, 3, 'h200, 0, 4, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL busy_start_timeout: got timeout, required done"); end
    n_cmp++; if (xfer_cnt !== exp_n) begin n_bad++; $display("FAIL busy_start_count: got %0d, required %0d", xfer_cnt, exp_n); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL busy_start_done: got %0d, required 1", done_cnt); end
    n_cmp++; if (rd_cnt !== exp_reads) begin n_bad++; $display("FAIL busy_start_reads: got %0d, required %0d", rd_cnt, exp_reads); end
  endtask

  task automatic test_reset_mid();
    bit to;
    logic [AW+DW+7:0] v;
    mem_key = 8'h21;
    mon_clear();
    build_expected(5, 4, 'h80);
    @(posedge clk); #1;
    t0 = cyc;
    frame_column_size = SW'(5); frame_row_size = SW'(4); base_addr = AW'('h80);
    out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    v = {mem_rd_en, mem_addr, out_valid, out_point, out_sol, out_eol, out_sof, out_eof, busy, done};
    n_cmp++;
    if (v !== '0) begin n_bad++; $display("FAIL midreset_outputs: got %h, required 0", v); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL midreset_done: got %0d pulses, required 0", done_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b, required 0", busy); end
    run_frame(4, 3, 'h300, 0, -1, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL midreset_timeout: got timeout, required done"); end
    n_cmp++; if (xfer_cnt !== exp_n) begin n_bad++; $display("FAIL midreset_count: got %0d, required %0d", xfer_cnt, exp_n); end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL midreset_missing: got %0d left, required 0", exp_q.size()); end
    n_cmp++; if (done_rel !== 3 + exp_n) begin n_bad++; $display("FAIL midreset_done_cycle: got %0d, required %0d", done_rel, 3 + exp_n); end
    n_cmp++; if (rd_cnt !== exp_reads) begin n_bad++; $display("FAIL midreset_reads: got %0d, required %0d", rd_cnt, exp_reads); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_random(7, 5);
    test_random(int'($urandom_range(1, 9)), int'($urandom_range(1, 6)));
    test_small_frame();
    test_zero(0, 3);
    test_zero(5, 0);
    test_start_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
